// File: rtl/kernel_fetch_pkg.sv
// Shared kernel-SRAM constants and the fetch FSM state type.
package kernel_fetch_pkg;
  localparam int KF_WORD_AMOUNT  = 1152;
  localparam int KF_BIT_PER_WORD = 73;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } kf_state_e;
endpackage

// File: rtl/kfetch_fifo.sv
// 2-entry FIFO holding SRAM words (plus their last flag) until the consumer takes them.
module kfetch_fifo #(
  parameter int W = 74
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         valid,
  output logic [1:0]   count
);
  logic [1:0][W-1:0] mem_q, mem_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic [1:0]        cnt_q, cnt_d;

  // The producer never pushes into a full FIFO; overflow is prevented upstream.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push) begin
      mem_d[wr_q] = wdata;
      wr_d        = ~wr_q;
    end
    if (pop) rd_d = ~rd_q;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign rdata = mem_q[rd_q];
  assign valid = (cnt_q != 2'd0);
  assign count = cnt_q;
endmodule

// File: rtl/kernel_fetch.sv
// Streams a block of kernel SRAM words (1-cycle read latency) to a valid/ready port.
// Optional KFETCH_REPEAT_EN replays the block repeat_cnt+1 times.
module kernel_fetch
  import kernel_fetch_pkg::*;
#(
  parameter int WORD_AMOUNT  = KF_WORD_AMOUNT,
  parameter int BIT_PER_WORD = KF_BIT_PER_WORD,
  parameter int AW           = $clog2(WORD_AMOUNT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [AW-1:0]           base_addr,
  input  logic [AW:0]             length,
`ifdef KFETCH_REPEAT_EN
  input  logic [7:0]              repeat_cnt,
`endif
  output logic                    busy,
  output logic                    done,
  output logic                    sram_we,
  output logic [AW-1:0]           sram_addr,
  output logic                    sram_final,
  input  logic [BIT_PER_WORD-1:0] sram_rdata,
  output logic [BIT_PER_WORD-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last
);
  localparam logic [AW-1:0] LAST_ADDR = AW'(WORD_AMOUNT - 1);

  kf_state_e     state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   remain_q, remain_d;
  logic          infl_q, infl_d;
  logic          infl_last_q, infl_last_d;
  logic          done_q, done_d;
`ifdef KFETCH_REPEAT_EN
  logic [AW-1:0] base_q, base_d;
  logic [AW:0]   len_q, len_d;
  logic [7:0]    pass_q, pass_d;
`endif

  logic       final_pass, last_issue, can_issue, issue, pop, head_last;
  logic [1:0] fifo_cnt;
  logic [2:0] occ;

`ifdef KFETCH_REPEAT_EN
  assign final_pass = (pass_q == 8'd0);
`else
  assign final_pass = 1'b1;
`endif

  assign pop        = out_valid & out_ready;
  assign last_issue = (remain_q == (AW+1)'(1));
  // Words already buffered or still returning from SRAM, minus the one leaving now.
  assign occ        = 3'(fifo_cnt) + 3'(infl_q) - 3'(pop);
  assign can_issue  = (occ < 3'd2);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remain_d    = remain_q;
    done_d      = 1'b0;
    issue       = 1'b0;
    sram_final  = 1'b0;
`ifdef KFETCH_REPEAT_EN
    base_d      = base_q;
    len_d       = len_q;
    pass_d      = pass_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d   = base_addr;
          remain_d = length;
`ifdef KFETCH_REPEAT_EN
          base_d   = base_addr;
          len_d    = length;
          pass_d   = repeat_cnt;
`endif
          if (length == '0) done_d = 1'b1;
          else              state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (can_issue) begin
          issue      = 1'b1;
          sram_final = last_issue & final_pass;
          addr_d     = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
          remain_d   = remain_q - 1'b1;
          if (last_issue) begin
            if (final_pass) begin
              state_d = ST_DRAIN;
            end else begin
`ifdef KFETCH_REPEAT_EN
              addr_d   = base_q;
              remain_d = len_q;
              pass_d   = pass_q - 8'd1;
`endif
            end
          end
        end
      end
      ST_DRAIN: begin
        if (pop && out_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    infl_d      = issue;
    infl_last_d = sram_final;
  end

  // Clearing the in-flight flag on reset drops any word still coming back from SRAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef KFETCH_REPEAT_EN
      base_q      <= '0;
      len_q       <= '0;
      pass_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      done_q      <= done_d;
`ifdef KFETCH_REPEAT_EN
      base_q      <= base_d;
      len_q       <= len_d;
      pass_q      <= pass_d;
`endif
    end
  end

  kfetch_fifo #(.W(BIT_PER_WORD + 1)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (infl_q),
    .wdata ({infl_last_q, sram_rdata}),
    .pop   (pop),
    .rdata ({head_last, out_data}),
    .valid (out_valid),
    .count (fifo_cnt)
  );

  assign out_last  = out_valid & head_last;
  assign busy      = (state_q != ST_IDLE) | done_q;
  assign done      = done_q;
  assign sram_we   = 1'b0;
  assign sram_addr = addr_q;
endmodule
